serial_paralelo1: RTL and testbench

- Receive-side neighbour of the transmit paralelo_serial1 stage.
- Consumes the LSB-first serial stream, which carries 8'hBC (K28.5) when idle.
- Finds byte alignment by hunting for the comma, then declares link active after BC_COUNT consecutive aligned commas.
- Delivers recovered bytes with a valid flag and a one-cycle byte strobe, all in the bit-clock domain.

---
 rtl/serial_paralelo1.sv | 149 ++++++++++++++
 tb/tb_serial_paralelo1.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo1.sv
// serial_paralelo1: receive-side deserializer for the LSB-first serial stream
// produced by paralelo_serial1. Hunts for the comma byte at any bit offset,
// locks byte alignment, and declares the link active after BC_COUNT
// consecutive aligned commas. Everything runs in the bit-clock domain.
module serial_paralelo1 #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_strobe
);

  // Required run of aligned commas, sized to the 4-bit comma counter.
  localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ALIGNED = 2'd1,
    SYNC    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] sr;
  logic [7:0] sr_next;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_nxt;
  logic [3:0] comma_cnt;
  logic [3:0] comma_cnt_nxt;
  logic [3:0] comma_cnt_inc;
  logic [7:0] data_nxt;
  logic       valid_nxt;
  logic       strobe_nxt;
  logic       is_comma;
  logic       boundary;

  // Comma counter increment that never runs past the lock threshold.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    if (cnt >= BC_TARGET) begin
      return cnt;
    end
    return cnt + 4'd1;
  endfunction

  // The newest bit enters at the top, so after eight LSB-first bits the
  // shift register holds the transmitted byte in natural order.
  assign sr_next       = {data_in, sr[7:1]};
  assign is_comma      = (sr_next == COMMA);
  assign boundary      = (bit_cnt == 3'd7);
  assign comma_cnt_inc = sat_inc(comma_cnt);

  // The link is declared active exactly while the FSM sits in SYNC.
  assign active = (state == SYNC);

  // Serial shift register, cleared on reset so stale bits cannot fake a comma.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr <= 8'h00;
    end else begin
      sr <= sr_next;
    end
  end

  // State, counters and output registers; reset discards any partial byte.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state       <= HUNT;
      bit_cnt     <= 3'd0;
      comma_cnt   <= 4'd0;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      comma_cnt   <= comma_cnt_nxt;
      data_out    <= data_nxt;
      valid_out   <= valid_nxt;
      byte_strobe <= strobe_nxt;
    end
  end

  // Next-state and output decisions; outputs hold unless a byte completes.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    comma_cnt_nxt = comma_cnt;
    data_nxt      = data_out;
    valid_nxt     = valid_out;
    strobe_nxt    = 1'b0;

    case (state)
      HUNT: begin
        // Sliding comparison every bit: alignment may appear at any offset.
        bit_cnt_nxt = 3'd0;
        if (is_comma) begin
          state_nxt     = (BC_TARGET == 4'd1) ? SYNC : ALIGNED;
          comma_cnt_nxt = 4'd1;
          data_nxt      = COMMA;
          strobe_nxt    = 1'b1;
          valid_nxt     = 1'b0;
        end
      end

      ALIGNED: begin
        // Counter restarted at the match, so the next boundary is 8 bits on.
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          data_nxt   = sr_next;
          strobe_nxt = 1'b1;
          valid_nxt  = 1'b0;
          if (is_comma) begin
            comma_cnt_nxt = comma_cnt_inc;
            if (comma_cnt_inc == BC_TARGET) begin
              state_nxt = SYNC;
            end
          end else begin
            // A non-comma before lock means the alignment guess was wrong.
            state_nxt     = HUNT;
            comma_cnt_nxt = 4'd0;
          end
        end
      end

      SYNC: begin
        // Locked: only reset leaves SYNC; commas read as idle, not data.
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          data_nxt   = sr_next;
          strobe_nxt = 1'b1;
          valid_nxt  = !is_comma;
        end
      end

      default: begin
        state_nxt     = HUNT;
        bit_cnt_nxt   = 3'd0;
        comma_cnt_nxt = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_paralelo1.sv
// Directed bench for serial_paralelo1: alignment, lock, data delivery,
// misalignment recovery, mid-byte reset and the single-comma lock variant.
module tb_serial_paralelo1;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_strobe;

  logic       reset1;
  logic       data_in1;
  logic [7:0] data_out1;
  logic       valid_out1;
  logic       active1;
  logic       byte_strobe1;

  int tests = 0;
  int fails = 0;

  serial_paralelo1 #(.COMMA(8'hBC), .BC_COUNT(4)) u_dut (
    .clk_32f    (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .active     (active),
    .byte_strobe(byte_strobe)
  );

  serial_paralelo1 #(.COMMA(8'hBC), .BC_COUNT(1)) u_dut1 (
    .clk_32f    (clk),
    .reset      (reset1),
    .data_in    (data_in1),
    .data_out   (data_out1),
    .valid_out  (valid_out1),
    .active     (active1),
    .byte_strobe(byte_strobe1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bit, strobe expected low (used for misaligned lead-in bits).
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
    check("strobe_idle_bit", byte_strobe, 1'b0);
  endtask

  // One byte LSB-first to the selected instance; strobe must fire only on
  // the 8th bit, and optionally valid_out must hold its previous value.
  task automatic send_byte(input int sel, input logic [7:0] b,
                           input logic chk_valid, input logic prev_valid);
    for (int i = 0; i < 8; i++) begin
      if (sel == 0) data_in = b[i];
      else          data_in1 = b[i];
      @(posedge clk);
      #1;
      check($sformatf("strobe_%02h_bit%0d", b, i),
            (sel == 0) ? byte_strobe : byte_strobe1, (i == 7));
      if (chk_valid && i < 7)
        check($sformatf("valid_hold_%02h_bit%0d", b, i),
              (sel == 0) ? valid_out : valid_out1, prev_valid);
    end
  endtask

  initial begin
    reset    = 1'b1;
    data_in  = 1'b0;
    reset1   = 1'b1;
    data_in1 = 1'b0;

    // Reset held 3 cycles, then four commas lock the link on the 4th.
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", valid_out, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_strobe", byte_strobe, 1'b0);
    reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      send_byte(0, 8'hBC, 1'b1, 1'b0);
      check($sformatf("t1_active_after_%0d", n), active, (n == 4));
      check($sformatf("t1_data_after_%0d", n), data_out, 8'hBC);
      check($sformatf("t1_valid_after_%0d", n), valid_out, 1'b0);
    end

    // Data after lock: A5, BC, 3C, then a comma to close the 3C period.
    send_byte(0, 8'hA5, 1'b1, 1'b0);
    check("t2_data_a5", data_out, 8'hA5);
    check("t2_valid_a5", valid_out, 1'b1);
    send_byte(0, 8'hBC, 1'b1, 1'b1);
    check("t2_data_bc", data_out, 8'hBC);
    check("t2_valid_bc", valid_out, 1'b0);
    send_byte(0, 8'h3C, 1'b1, 1'b0);
    check("t2_data_3c", data_out, 8'h3C);
    check("t2_valid_3c", valid_out, 1'b1);
    send_byte(0, 8'hBC, 1'b1, 1'b1);
    check("t2_valid_bc2", valid_out, 1'b0);
    check("t2_active", active, 1'b1);

    // Three misaligning bits, then commas and a data byte.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int n = 1; n <= 4; n++) begin
      send_byte(0, 8'hBC, 1'b1, 1'b0);
      check($sformatf("t3_active_after_%0d", n), active, (n == 4));
    end
    send_byte(0, 8'h55, 1'b1, 1'b0);
    check("t3_data_55", data_out, 8'h55);
    check("t3_valid_55", valid_out, 1'b1);

    // Two commas, a data byte before lock drops back to hunting.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_byte(0, 8'hBC, 1'b1, 1'b0);
    send_byte(0, 8'hBC, 1'b1, 1'b0);
    send_byte(0, 8'h12, 1'b1, 1'b0);
    check("t4_data_12", data_out, 8'h12);
    check("t4_valid_12", valid_out, 1'b0);
    check("t4_active_12", active, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      send_byte(0, 8'hBC, 1'b1, 1'b0);
      check($sformatf("t4_active_after_%0d", n), active, (n == 4));
    end

    // Mid-byte reset while in SYNC with valid_out high.
    send_byte(0, 8'h3C, 1'b1, 1'b0);
    check("t5_valid_pre", valid_out, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    check("t5_valid_held", valid_out, 1'b1);
    reset   = 1'b1;
    data_in = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t5_active", active, 1'b0);
    check("t5_valid", valid_out, 1'b0);
    check("t5_data", data_out, 8'h00);
    check("t5_strobe", byte_strobe, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      send_byte(0, 8'hBC, 1'b1, 1'b0);
      check($sformatf("t5_active_after_%0d", n), active, (n == 4));
    end

    // Single-comma lock variant.
    check("t6_rst_active", active1, 1'b0);
    check("t6_rst_data", data_out1, 8'h00);
    reset1 = 1'b0;
    send_byte(1, 8'hBC, 1'b1, 1'b0);
    check("t6_active_bc", active1, 1'b1);
    check("t6_data_bc", data_out1, 8'hBC);
    check("t6_valid_bc", valid_out1, 1'b0);
    send_byte(1, 8'hF0, 1'b1, 1'b0);
    check("t6_data_f0", data_out1, 8'hF0);
    check("t6_valid_f0", valid_out1, 1'b1);
    check("t6_active_f0", active1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
